// File: rtl/imm_ext_pipe.sv
// Multi-lane immediate extender: stage 1 zero/sign-extends each lane's raw immediate,
// stage 2 applies the per-lane left shift, flags lost bits and counts overflowing transfers.
module imm_ext_pipe #(
    parameter int LANES = 2,
    parameter int IN_W  = 11,
    parameter int OUT_W = 32,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_imm,
    input  logic [LANES*2-1:0]     in_mode,
    input  logic [LANES*2-1:0]     in_shl,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_imm,
    output logic [LANES-1:0]       out_ovf,
    input  logic                   cnt_clr,
    output logic [CNT_W-1:0]       ovf_cnt
);

    // Handshake: a bundle moves across a boundary on a cycle where valid and
    // ready are both high; a stage advances when it is empty or its
    // downstream takes its bundle. in_ready depends only on state and out_ready.

    logic                   s1_valid_q, s1_valid_d;
    logic [LANES*OUT_W-1:0] s1_ext_q, s1_ext_d;
    logic [LANES*2-1:0]     s1_shl_q, s1_shl_d;
    logic [LANES-1:0]       s1_se_q, s1_se_d;

    logic                   s2_valid_q, s2_valid_d;
    logic [LANES*OUT_W-1:0] out_imm_q, out_imm_d;
    logic [LANES-1:0]       out_ovf_q, out_ovf_d;

    logic [CNT_W-1:0]       ovf_cnt_q, ovf_cnt_d;

    logic                   s1_adv;
    logic                   s2_adv;
    logic [LANES*OUT_W-1:0] ext_val;
    logic [LANES*OUT_W-1:0] sh_val;
    logic [LANES-1:0]       sh_ovf;
    logic [LANES-1:0]       mode_se;
    logic [OUT_W-1:0]       lane_e;
    logic [OUT_W-1:0]       lane_sh;
    logic [OUT_W-1:0]       lane_back;

    // 8-bit modes look only at raw[7:0]; the upper raw bits are ignored.
    always_comb begin
        ext_val = '0;
        mode_se = '0;
        for (int k = 0; k < LANES; k++) begin
            mode_se[k] = in_mode[2*k];
            case (in_mode[2*k +: 2])
                2'b00:   ext_val[k*OUT_W +: OUT_W] = {{(OUT_W-8){1'b0}}, in_imm[k*IN_W +: 8]};
                2'b01:   ext_val[k*OUT_W +: OUT_W] = {{(OUT_W-8){in_imm[k*IN_W+7]}}, in_imm[k*IN_W +: 8]};
                2'b10:   ext_val[k*OUT_W +: OUT_W] = {{(OUT_W-IN_W){1'b0}}, in_imm[k*IN_W +: IN_W]};
                default: ext_val[k*OUT_W +: OUT_W] = {{(OUT_W-IN_W){in_imm[k*IN_W+IN_W-1]}},
                                                      in_imm[k*IN_W +: IN_W]};
            endcase
        end
    end

    // Overflow means shifting back (arithmetic for signed lanes) does not restore E.
    always_comb begin
        sh_val    = '0;
        sh_ovf    = '0;
        lane_e    = '0;
        lane_sh   = '0;
        lane_back = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_e  = s1_ext_q[k*OUT_W +: OUT_W];
            lane_sh = lane_e << s1_shl_q[2*k +: 2];
            if (s1_se_q[k]) begin
                lane_back = $signed(lane_sh) >>> s1_shl_q[2*k +: 2];
            end else begin
                lane_back = lane_sh >> s1_shl_q[2*k +: 2];
            end
            sh_val[k*OUT_W +: OUT_W] = lane_sh;
            sh_ovf[k]                = (lane_back != lane_e);
        end
    end

    always_comb begin
        s2_adv     = !s2_valid_q || out_ready;
        s1_adv     = !s1_valid_q || s2_adv;

        s1_valid_d = s1_valid_q;
        s1_ext_d   = s1_ext_q;
        s1_shl_d   = s1_shl_q;
        s1_se_d    = s1_se_q;
        s2_valid_d = s2_valid_q;
        out_imm_d  = out_imm_q;
        out_ovf_d  = out_ovf_q;
        ovf_cnt_d  = ovf_cnt_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_ext_d = ext_val;
                s1_shl_d = in_shl;
                s1_se_d  = mode_se;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_imm_d = sh_val;
                out_ovf_d = sh_ovf;
            end
        end

        // Clear wins over an increment in the same cycle; the count saturates.
        if (cnt_clr) begin
            ovf_cnt_d = '0;
        end else if (s2_valid_q && out_ready && (|out_ovf_q) && (ovf_cnt_q != {CNT_W{1'b1}})) begin
            ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_ext_q   <= '0;
            s1_shl_q   <= '0;
            s1_se_q    <= '0;
            s2_valid_q <= 1'b0;
            out_imm_q  <= '0;
            out_ovf_q  <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_ext_q   <= s1_ext_d;
            s1_shl_q   <= s1_shl_d;
            s1_se_q    <= s1_se_d;
            s2_valid_q <= s2_valid_d;
            out_imm_q  <= out_imm_d;
            out_ovf_q  <= out_ovf_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign out_imm   = out_imm_q;
    assign out_ovf   = out_ovf_q;
    assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: a default-parameter instance plus a narrow
// (OUT_W=12, CNT_W=2) instance sharing the same inputs for shift-overflow and saturation cases.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [21:0] in_imm;
    logic [3:0]  in_mode;
    logic [3:0]  in_shl;
    logic        out_ready;
    logic        cnt_clr;

    logic        in_ready_a, out_valid_a;
    logic [63:0] out_imm_a;
    logic [1:0]  out_ovf_a;
    logic [7:0]  ovf_cnt_a;

    logic        in_ready_b, out_valid_b;
    logic [23:0] out_imm_b;
    logic [1:0]  out_ovf_b;
    logic [1:0]  ovf_cnt_b;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    imm_ext_pipe u_dut_a (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .in_imm(in_imm), .in_mode(in_mode), .in_shl(in_shl),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_imm(out_imm_a), .out_ovf(out_ovf_a),
        .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt_a)
    );

    imm_ext_pipe #(.LANES(2), .IN_W(11), .OUT_W(12), .CNT_W(2)) u_dut_b (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .in_imm(in_imm), .in_mode(in_mode), .in_shl(in_shl),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_imm(out_imm_b), .out_ovf(out_ovf_b),
        .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [10:0] i1, input logic [10:0] i0,
                         input logic [1:0] m1, input logic [1:0] m0,
                         input logic [1:0] s1, input logic [1:0] s0);
        in_valid = 1'b1;
        in_imm   = {i1, i0};
        in_mode  = {m1, m0};
        in_shl   = {s1, s0};
    endtask

    // Present one bundle, let it be accepted, and return when it sits on out_*.
    task automatic send(input logic [10:0] i1, input logic [10:0] i0,
                        input logic [1:0] m1, input logic [1:0] m0,
                        input logic [1:0] s1, input logic [1:0] s0);
        drive(i1, i0, m1, m0, s1, s0);
        #1;
        chk("send_in_ready", in_ready_a, 1);
        step();
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        int          idx;
        int          got;
        logic [63:0] e;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_mode   = '0;
        in_shl    = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_in_ready", in_ready_a, 1);
        chk("rst_out_imm", out_imm_a, 64'h0);
        chk("rst_out_ovf", out_ovf_a, 0);
        chk("rst_cnt", ovf_cnt_a, 0);
        step();

        // T1: sign extension from bit 7 and from bit IN_W-1
        send(11'h480, 11'h080, 2'b11, 2'b01, 2'd0, 2'd0);
        chk("t1_valid", out_valid_a, 1);
        chk("t1_imm", out_imm_a, 64'hFFFFFC80_FFFFFF80);
        chk("t1_ovf", out_ovf_a, 2'b00);
        step();

        // T2: zero extension, then a shifted SE11 lane
        send(11'h7FF, 11'h7FF, 2'b10, 2'b00, 2'd0, 2'd0);
        chk("t2_ze_imm", out_imm_a, 64'h000007FF_000000FF);
        step();
        send(11'h000, 11'h3FF, 2'b00, 2'b11, 2'd3, 2'd2);
        chk("t2_shl_imm", out_imm_a, 64'h00000000_00000FFC);
        chk("t2_shl_ovf", out_ovf_a, 2'b00);
        step();
        chk("t2_cnt", ovf_cnt_a, 0);

        // T3: four back-to-back bundles into a stalled consumer
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 7; c++) begin
            in_valid = (idx < 4);
            in_imm   = {11'h200 + 11'(idx), 11'h100 + 11'(idx)};
            in_mode  = 4'b1010;
            in_shl   = 4'b0000;
            #1;
            if (c >= 2) begin
                chk("t3_stall_ready", in_ready_a, 0);
                chk("t3_stall_valid", out_valid_a, 1);
                chk("t3_stall_imm", out_imm_a, 64'h00000200_00000100);
            end
            if (in_valid && in_ready_a) begin
                exp_q.push_back({32'h200 + 32'(idx), 32'h100 + 32'(idx)});
                idx++;
            end
            step();
        end
        chk("t3_accepted_during_stall", idx, 2);
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 12 && got < 4; c++) begin
            in_valid = (idx < 4);
            in_imm   = {11'h200 + 11'(idx), 11'h100 + 11'(idx)};
            #1;
            if (out_valid_a) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e = 64'hDEAD_DEAD_DEAD_DEAD;
                chk("t3_order", out_imm_a, e);
                got++;
            end
            if (in_valid && in_ready_a) begin
                exp_q.push_back({32'h200 + 32'(idx), 32'h100 + 32'(idx)});
                idx++;
            end
            step();
        end
        in_valid = 1'b0;
        #1;
        chk("t3_got", got, 4);
        chk("t3_left", exp_q.size(), 0);
        chk("t3_drained", out_valid_a, 0);
        step();

        // T4: narrow instance, shift overflow in both extension kinds
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("t4_cnt_clr", ovf_cnt_b, 0);
        send(11'h400, 11'h400, 2'b11, 2'b11, 2'd2, 2'd1);
        chk("t4_se_imm_b", out_imm_b, 24'h000_800);
        chk("t4_se_ovf_b", out_ovf_b, 2'b10);
        chk("t4_se_imm_a", out_imm_a, 64'hFFFFF000_FFFFF800);
        chk("t4_se_ovf_a", out_ovf_a, 2'b00);
        step();
        send(11'h7FF, 11'h7FF, 2'b10, 2'b10, 2'd2, 2'd1);
        chk("t4_ze_imm_b", out_imm_b, 24'hFFC_FFE);
        chk("t4_ze_ovf_b", out_ovf_b, 2'b10);
        chk("t4_ze_imm_a", out_imm_a, 64'h00001FFC_00000FFE);
        step();
        chk("t4_cnt_b", ovf_cnt_b, 2);
        chk("t4_cnt_a", ovf_cnt_a, 0);

        // T5: saturation, then clear beating a same-cycle increment
        for (int n = 0; n < 3; n++) begin
            send(11'h400, 11'h400, 2'b11, 2'b11, 2'd2, 2'd1);
            step();
        end
        chk("t5_cnt_sat", ovf_cnt_b, 3);
        send(11'h400, 11'h400, 2'b11, 2'b11, 2'd2, 2'd1);
        chk("t5_ovf_present", out_ovf_b, 2'b10);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("t5_clr_wins", ovf_cnt_b, 0);
        step();
        chk("t5_clr_held", ovf_cnt_b, 0);

        // T6: reset while both stages are full and the consumer is stalled
        send(11'h400, 11'h400, 2'b11, 2'b11, 2'd2, 2'd1);
        step();
        chk("t6_cnt_pre", ovf_cnt_b, 1);
        out_ready = 1'b0;
        drive(11'h400, 11'h400, 2'b11, 2'b11, 2'd2, 2'd1);
        step();
        drive(11'h7FF, 11'h7FF, 2'b10, 2'b10, 2'd2, 2'd1);
        step();
        in_valid = 1'b0;
        #1;
        chk("t6_full_ready", in_ready_a, 0);
        chk("t6_full_valid", out_valid_a, 1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("t6_rst_valid", out_valid_a, 0);
        chk("t6_rst_ready", in_ready_a, 1);
        chk("t6_rst_cnt_b", ovf_cnt_b, 0);
        chk("t6_rst_imm", out_imm_a, 64'h0);
        chk("t6_rst_ovf_b", out_ovf_b, 2'b00);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t6_no_stale", out_valid_a, 0);
        end
        chk("t6_cnt_after", ovf_cnt_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
